tt_um_onehot_accum: RTL and testbench

TT_UM_ONEHOT_ACCUM -- requirements
Module: tt_um_onehot_accum

---
 rtl/tt_um_onehot_accum.sv | 179 +++++++++++++++++
 tb/tb_tt_um_onehot_accum.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_onehot_accum.sv
// rtl/tt_um_onehot_accum.sv - one-hot sample histogram and running total with framed report stream
module tt_um_onehot_accum #(
  parameter int FRAME_LEN = 16,
  parameter int HIST_W    = 8,
  parameter int ACC_W     = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [4:0]       onehot,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_tag,
  output logic [ACC_W-1:0] out_data,
  output logic             err
);

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_REPORT = 1'b1
  } state_t;

  localparam logic [HIST_W-1:0] BIN_MAX    = '1;
  localparam logic [ACC_W-1:0]  ACC_MAX    = '1;
  localparam logic [7:0]        FRAME_LAST = 8'(FRAME_LEN - 1);
  localparam logic [2:0]        TAG_TOTAL  = 3'd5;

  state_t            state_q, state_d;
  logic [HIST_W-1:0] bin_q [5];
  logic [HIST_W-1:0] bin_d [5];
  logic [ACC_W-1:0]  total_q, total_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              err_q, err_d;
  logic [2:0]        out_tag_q, out_tag_d;
  logic [ACC_W-1:0]  out_data_q, out_data_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic              accept;
  logic              onehot_single;
  logic [2:0]        sample_k;
  logic [ACC_W:0]    total_sum;

  // Decode the incoming sample: is it exactly one-hot, and which count does it carry
  always_comb begin
    accept        = in_valid & in_ready_q;
    onehot_single = (onehot != 5'd0) && ((onehot & (onehot - 5'd1)) == 5'd0);
    sample_k      = 3'd0;
    case (onehot)
      5'b00001: sample_k = 3'd0;
      5'b00010: sample_k = 3'd1;
      5'b00100: sample_k = 3'd2;
      5'b01000: sample_k = 3'd3;
      5'b10000: sample_k = 3'd4;
      default:  sample_k = 3'd0;
    endcase
    // One extra bit catches overflow so the total can clamp instead of wrapping
    total_sum = {1'b0, total_q} + {{(ACC_W-2){1'b0}}, sample_k};
  end

  // Next-state logic: accumulate in ACCUM, walk the six report words in REPORT; clear overrides all
  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;
    out_tag_d   = out_tag_q;
    for (int i = 0; i < 5; i++) begin
      bin_d[i] = bin_q[i];
    end

    if (clear) begin
      state_d     = ST_ACCUM;
      total_d     = '0;
      frame_cnt_d = '0;
      err_d       = 1'b0;
      out_tag_d   = 3'd0;
      for (int i = 0; i < 5; i++) begin
        bin_d[i] = '0;
      end
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept) begin
            if (!onehot_single) begin
              // Malformed sample is consumed but never counted
              err_d = 1'b1;
            end else begin
              for (int i = 0; i < 5; i++) begin
                if ((sample_k == 3'(i)) && (bin_q[i] != BIN_MAX)) begin
                  bin_d[i] = bin_q[i] + 1'b1;
                end
              end
              total_d     = total_sum[ACC_W] ? ACC_MAX : total_sum[ACC_W-1:0];
              frame_cnt_d = frame_cnt_q + 8'd1;
              if (frame_cnt_q == FRAME_LAST) begin
                state_d   = ST_REPORT;
                out_tag_d = 3'd0;
              end
            end
          end
        end
        ST_REPORT: begin
          if (out_ready) begin
            if (out_tag_q == TAG_TOTAL) begin
              // Last word taken: start a fresh frame, err stays sticky
              state_d     = ST_ACCUM;
              out_tag_d   = 3'd0;
              total_d     = '0;
              frame_cnt_d = '0;
              for (int i = 0; i < 5; i++) begin
                bin_d[i] = '0;
              end
            end else begin
              out_tag_d = out_tag_q + 3'd1;
            end
          end
        end
        default: state_d = ST_ACCUM;
      endcase
    end
  end

  // Registered outputs derive from the next state so they line up with it after the edge
  always_comb begin
    in_ready_d  = (state_d == ST_ACCUM);
    out_valid_d = (state_d == ST_REPORT);
    out_data_d  = '0;
    if (state_d == ST_REPORT) begin
      case (out_tag_d)
        3'd0:    out_data_d = ACC_W'(bin_d[0]);
        3'd1:    out_data_d = ACC_W'(bin_d[1]);
        3'd2:    out_data_d = ACC_W'(bin_d[2]);
        3'd3:    out_data_d = ACC_W'(bin_d[3]);
        3'd4:    out_data_d = ACC_W'(bin_d[4]);
        3'd5:    out_data_d = total_d;
        default: out_data_d = '0;
      endcase
    end
  end

  // State, counters and registered outputs; asynchronous reset lands in an idle ACCUM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      total_q     <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
      out_tag_q   <= 3'd0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        bin_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
      out_tag_q   <= out_tag_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < 5; i++) begin
        bin_q[i] <= bin_d[i];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_tag   = out_tag_q;
  assign out_data  = out_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_tt_um_onehot_accum.sv
// tb/tb_tt_um_onehot_accum.sv - scoreboard bench for tt_um_onehot_accum
module tb_tt_um_onehot_accum;

  typedef struct packed {
    logic [2:0]  tag;
    logic [11:0] data;
  } word_t;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [4:0]  onehot;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_tag;
  logic [11:0] out_data;
  logic        err;

  logic        clear2;
  logic        in_valid2;
  logic [4:0]  onehot2;
  logic        in_ready2;
  logic        out_valid2;
  logic        out_ready2;
  logic [2:0]  out_tag2;
  logic [11:0] out_data2;
  logic        err2;

  word_t exp_q[$];
  word_t exp2_q[$];
  int    n_total;
  int    n_bad;

  tt_um_onehot_accum #(.FRAME_LEN(4), .HIST_W(8), .ACC_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .onehot(onehot),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_data(out_data), .err(err)
  );

  tt_um_onehot_accum #(.FRAME_LEN(5), .HIST_W(2), .ACC_W(12)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear2), .in_valid(in_valid2), .onehot(onehot2),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_tag(out_tag2), .out_data(out_data2), .err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard for the main instance: every accepted report word is popped and compared
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      word_t e;
      n_total++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_word: got tag=%0d data=%0d, required no word", out_tag, out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_tag !== e.tag || out_data !== e.data) begin
          n_bad++;
          $display("FAIL report_word: got tag=%0d data=%0d, required tag=%0d data=%0d",
                   out_tag, out_data, e.tag, e.data);
        end
      end
    end
  end

  task automatic push_frame(ref word_t q[$], input int b0, b1, b2, b3, b4, tot);
    q.push_back({3'd0, 12'(b0)});
    q.push_back({3'd1, 12'(b1)});
    q.push_back({3'd2, 12'(b2)});
    q.push_back({3'd3, 12'(b3)});
    q.push_back({3'd4, 12'(b4)});
    q.push_back({3'd5, 12'(tot)});
  endtask

  task automatic send(input logic [4:0] oh);
    in_valid = 1'b1;
    onehot   = oh;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    onehot   = 5'd0;
  endtask

  task automatic send2(input logic [4:0] oh);
    in_valid2 = 1'b1;
    onehot2   = oh;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    onehot2   = 5'd0;
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1;
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d words pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_err", err, 0);
    chk("reset_out_tag", out_tag, 0);
    chk("reset_out_data", out_data, 0);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    push_frame(exp_q, 1, 1, 1, 0, 1, 7);
    send(5'b00001);
    send(5'b00100);
    send(5'b10000);
    chk("b2b_in_ready_before_last", in_ready, 1);
    send(5'b00010);
    chk("b2b_in_ready_after_last", in_ready, 0);
    chk("b2b_first_tag", out_tag, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("b2b_report_in_ready", in_ready, 0);
      chk("b2b_report_out_valid", out_valid, 1);
    end
    @(posedge clk);
    #1;
    chk("b2b_in_ready_after", in_ready, 1);
    chk("b2b_out_valid_after", out_valid, 0);
    chk("b2b_words_left", exp_q.size(), 0);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push_frame(exp_q, 1, 1, 1, 0, 1, 7);
    send(5'b00001);
    send(5'b00100);
    send(5'b10000);
    send(5'b00010);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_tag", out_tag, 0);
      chk("hold_data", out_data, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();
    chk("hold_in_ready_after", in_ready, 1);
  endtask

  task automatic test_err();
    out_ready = 1'b1;
    chk("err_before", err, 0);
    push_frame(exp_q, 0, 0, 0, 0, 4, 16);
    send(5'b00000);
    chk("err_after_zero", err, 1);
    send(5'b00011);
    chk("err_no_frame_from_bad", in_ready, 1);
    for (int i = 0; i < 4; i++) send(5'b10000);
    wait_drain();
    chk("err_sticky", err, 1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("err_cleared", err, 0);
    // Clear together with a malformed sample leaves err low
    clear    = 1'b1;
    in_valid = 1'b1;
    onehot   = 5'b00110;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    onehot   = 5'd0;
    chk("err_clear_wins", err, 0);
  endtask

  task automatic test_clear_report();
    out_ready = 1'b1;
    push_frame(exp_q, 1, 1, 1, 0, 1, 7);
    send(5'b00001);
    send(5'b00100);
    send(5'b10000);
    send(5'b00010);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_at_tag2", out_tag, 2);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("abort_no_more_words", out_valid, 0);
    // Clear concurrent with a good sample discards it
    @(posedge clk);
    #1;
    clear    = 1'b1;
    in_valid = 1'b1;
    onehot   = 5'b10000;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    onehot   = 5'd0;
    push_frame(exp_q, 4, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(5'b00001);
    wait_drain();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    send(5'b00001);
    send(5'b00010);
    send(5'b00000);
    chk("ar_err_set", err, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_in_ready", in_ready, 1);
    chk("ar_out_valid", out_valid, 0);
    chk("ar_err", err, 0);
    chk("ar_out_tag", out_tag, 0);
    chk("ar_out_data", out_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_frame(exp_q, 0, 0, 4, 0, 0, 8);
    send(5'b00100);
    send(5'b00100);
    send(5'b00100);
    chk("ar_no_early_report", out_valid, 0);
    send(5'b00100);
    wait_drain();
  endtask

  task automatic test_saturate();
    word_t e;
    out_ready2 = 1'b1;
    push_frame(exp2_q, 0, 0, 0, 3, 0, 15);
    for (int i = 0; i < 5; i++) send2(5'b01000);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      e = exp2_q.pop_front();
      chk("sat_out_valid", out_valid2, 1);
      n_total++;
      if (out_tag2 !== e.tag || out_data2 !== e.data) begin
        n_bad++;
        $display("FAIL sat_word: got tag=%0d data=%0d, required tag=%0d data=%0d",
                 out_tag2, out_data2, e.tag, e.data);
      end
    end
    @(posedge clk);
    #1;
    chk("sat_in_ready_after", in_ready2, 1);
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    clear      = 1'b0;
    in_valid   = 1'b0;
    onehot     = 5'd0;
    out_ready  = 1'b0;
    clear2     = 1'b0;
    in_valid2  = 1'b0;
    onehot2    = 5'd0;
    out_ready2 = 1'b0;
    #1;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_err();
    test_clear_report();
    test_async_reset();
    test_saturate();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
